// File: rtl/refund_dispenser.sv
// -----------------------------------------------------------------------------
// refund_dispenser
//
// Purpose:
//   Back end of a vending machine. Takes {cola, money} requests from the
//   vending FSM and runs them as a sequence of handshaked drive pulses: one
//   cola release, then one single-coin eject per half-yuan refunded. A
//   one-deep pending slot absorbs a request that arrives while a transaction
//   is running. Tracks coin stock and raises sticky status flags for
//   shortage, dropped requests and ack timeouts.
//
// Ports:
//   sys_clk      in   single clock, rising edge
//   sys_rst      in   synchronous, active-high reset
//   pi_cola      in   one-cycle pulse: release one cola
//   pi_money     in   [1:0] half-yuan coins to refund, sampled with pi_cola
//   cola_ack     in   cola mechanism done (used only while po_cola_drv=1)
//   coin_ack     in   one coin ejected (used only while po_coin_drv=1)
//   po_cola_drv  out  cola release drive, held until ack
//   po_coin_drv  out  single-coin eject drive, held until ack
//   po_busy      out  transaction running or request pending
//   po_coin_cnt  out  [7:0] remaining coin stock
//   po_short     out  sticky: a refund coin could not be paid
//   po_overflow  out  sticky: a request was dropped
//   po_fault     out  sticky: ack timeout, block halted until reset
// -----------------------------------------------------------------------------
module refund_dispenser #(
    parameter logic [7:0] COIN_INIT   = 8'd20,
    parameter int         ACK_TIMEOUT = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       pi_cola,
    input  logic [1:0] pi_money,
    input  logic       cola_ack,
    input  logic       coin_ack,
    output logic       po_cola_drv,
    output logic       po_coin_drv,
    output logic       po_busy,
    output logic [7:0] po_coin_cnt,
    output logic       po_short,
    output logic       po_overflow,
    output logic       po_fault
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_COLA  = 3'd1;
    localparam logic [2:0] ST_COIN  = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

    localparam int               TMO_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    logic [2:0]       state;
    logic             pend_valid;
    logic             pend_cola;
    logic [1:0]       pend_money;
    logic [1:0]       rem_money;
    logic [TMO_W-1:0] tmo_cnt;

    logic       req;
    logic       cola_ack_hit;
    logic       coin_ack_hit;
    logic       drv_on;
    logic       tmo_hit;
    logic       stock_out;
    logic       txn_done;
    logic       start_valid;
    logic       start_cola;
    logic [1:0] start_money;
    logic [2:0] done_state;

    assign req = pi_cola | (pi_money != 2'd0);

    // Acks only count while the matching drive is high; strays are ignored.
    assign cola_ack_hit = po_cola_drv & cola_ack;
    assign coin_ack_hit = po_coin_drv & coin_ack;
    assign drv_on       = po_cola_drv | po_coin_drv;

    // Drive has been high ACK_TIMEOUT cycles on this edge with no ack.
    assign tmo_hit = drv_on & ~cola_ack_hit & ~coin_ack_hit & (tmo_cnt == TMO_LAST);

    // About to raise a coin drive (first COIN cycle, or leaving GAP) with no
    // stock left: the remaining refund is abandoned.
    assign stock_out = (po_coin_cnt == 8'd0) &&
                       (((state == ST_COIN) && !po_coin_drv) || (state == ST_GAP));

    assign txn_done = ((state == ST_COLA) && cola_ack_hit && (rem_money == 2'd0)) ||
                      ((state == ST_COIN) && coin_ack_hit && (rem_money == 2'd1)) ||
                      stock_out;

    // Next transaction to launch: the pending slot has priority over the
    // request arriving this cycle.
    assign start_valid = pend_valid | req;
    assign start_cola  = pend_valid ? pend_cola  : pi_cola;
    assign start_money = pend_valid ? pend_money : pi_money;
    assign done_state  = !start_valid ? ST_IDLE : (start_cola ? ST_COLA : ST_COIN);

    assign po_busy = (state != ST_IDLE) | pend_valid;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= ST_IDLE;
            pend_valid  <= 1'b0;
            pend_cola   <= 1'b0;
            pend_money  <= 2'd0;
            rem_money   <= 2'd0;
            tmo_cnt     <= '0;
            po_cola_drv <= 1'b0;
            po_coin_drv <= 1'b0;
            po_coin_cnt <= COIN_INIT;
            po_short    <= 1'b0;
            po_overflow <= 1'b0;
            po_fault    <= 1'b0;
        end else if (state == ST_FAULT) begin
            pend_valid <= 1'b0;
        end else if (tmo_hit) begin
            state       <= ST_FAULT;
            po_cola_drv <= 1'b0;
            po_coin_drv <= 1'b0;
            po_fault    <= 1'b1;
            pend_valid  <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            tmo_cnt <= (drv_on && !cola_ack_hit && !coin_ack_hit) ? tmo_cnt + 1'b1 : '0;

            // Requests arriving while a transaction runs. On the ending edge
            // an incoming request with an empty slot launches directly.
            if (req && (state != ST_IDLE)) begin
                if (pend_valid) begin
                    po_overflow <= 1'b1;
                end else if (!txn_done) begin
                    pend_valid <= 1'b1;
                    pend_cola  <= pi_cola;
                    pend_money <= pi_money;
                end
            end

            if (stock_out) begin
                po_short <= 1'b1;
            end

            // Entering COLA/COIN leaves the drive low for one cycle; the drive
            // rises on the following edge, giving the one-cycle launch latency.
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        state     <= done_state;
                        rem_money <= start_money;
                    end
                end
                ST_COLA: begin
                    if (!po_cola_drv) begin
                        po_cola_drv <= 1'b1;
                    end else if (cola_ack_hit) begin
                        po_cola_drv <= 1'b0;
                        state       <= ST_GAP;
                    end
                end
                ST_COIN: begin
                    if (!po_coin_drv) begin
                        if (!stock_out) begin
                            po_coin_drv <= 1'b1;
                        end
                    end else if (coin_ack_hit) begin
                        po_coin_drv <= 1'b0;
                        if (po_coin_cnt != 8'd0) begin
                            po_coin_cnt <= po_coin_cnt - 8'd1;
                        end
                        rem_money <= rem_money - 2'd1;
                        state     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (!stock_out) begin
                        state       <= ST_COIN;
                        po_coin_drv <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // NOTE: with non-blocking assignments the last one in the block
            // wins, so this end-of-transaction hand-off overrides the GAP
            // transition and remaining-count update made above.
            if (txn_done) begin
                state      <= done_state;
                rem_money  <= start_money;
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_refund_dispenser.sv
// -----------------------------------------------------------------------------
// tb_refund_dispenser
//
// Purpose:
//   Self-checking bench for refund_dispenser. Expected drive pulses (kind and
//   low cycles before the rise) are queued when stimulus is issued; a monitor
//   pops and compares on each drive rise. Status outputs are compared
//   directly at scenario boundaries. A second instance with a one-coin stock
//   covers the shortage path.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_refund_dispenser;

    localparam int ACK_DELAY = 3;

    typedef enum logic {EV_COLA, EV_COIN} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       gap;   // low cycles before the rise; 0 = not checked
    } ev_t;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       pi_cola;
    logic [1:0] pi_money;
    logic       cola_ack;
    logic       coin_ack;
    logic       po_cola_drv;
    logic       po_coin_drv;
    logic       po_busy;
    logic [7:0] po_coin_cnt;
    logic       po_short;
    logic       po_overflow;
    logic       po_fault;

    logic       cola_ack_auto;
    logic       coin_ack_auto;
    logic       cola_stray;
    logic       coin_stray;
    logic       ack_en;

    logic       l_cola;
    logic [1:0] l_money;
    logic       l_cola_ack;
    logic       l_coin_ack;
    logic       l_cola_drv;
    logic       l_coin_drv;
    logic       l_busy;
    logic [7:0] l_coin_cnt;
    logic       l_short;
    logic       l_overflow;
    logic       l_fault;
    int         l_coin_pulses;

    int   checks = 0;
    int   errors = 0;
    ev_t  sb[$];
    int   low_run = 0;

    assign cola_ack = cola_ack_auto | cola_stray;
    assign coin_ack = coin_ack_auto | coin_stray;

    always #5 sys_clk = ~sys_clk;

    refund_dispenser #(
        .COIN_INIT  (8'd20),
        .ACK_TIMEOUT(16)
    ) u_dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .pi_cola    (pi_cola),
        .pi_money   (pi_money),
        .cola_ack   (cola_ack),
        .coin_ack   (coin_ack),
        .po_cola_drv(po_cola_drv),
        .po_coin_drv(po_coin_drv),
        .po_busy    (po_busy),
        .po_coin_cnt(po_coin_cnt),
        .po_short   (po_short),
        .po_overflow(po_overflow),
        .po_fault   (po_fault)
    );

    refund_dispenser #(
        .COIN_INIT  (8'd1),
        .ACK_TIMEOUT(16)
    ) u_low (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .pi_cola    (l_cola),
        .pi_money   (l_money),
        .cola_ack   (l_cola_ack),
        .coin_ack   (l_coin_ack),
        .po_cola_drv(l_cola_drv),
        .po_coin_drv(l_coin_drv),
        .po_busy    (l_busy),
        .po_coin_cnt(l_coin_cnt),
        .po_short   (l_short),
        .po_overflow(l_overflow),
        .po_fault   (l_fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual %0d required %0d", name, $time, act, exp);
        end
    endtask

    task automatic expect_pulse(input ev_kind_t kind, input int gap);
        ev_t e;
        e.kind = kind;
        e.gap  = gap;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input ev_kind_t kind);
        ev_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected at %0t: actual %s pulse required none", $time, kind.name());
        end else begin
            e = sb.pop_front();
            check("sb_kind", kind, e.kind);
            if (e.gap != 0) begin
                check("sb_gap", low_run, e.gap);
            end
        end
    endtask

    // Ack responders: ack raised on the ACK_DELAY-th sampled high cycle.
    initial begin
        int cola_hi;
        int coin_hi;
        int l_cola_hi;
        int l_coin_hi;
        logic l_prev;
        cola_hi = 0; coin_hi = 0; l_cola_hi = 0; l_coin_hi = 0; l_prev = 1'b0;
        cola_ack_auto = 1'b0;
        coin_ack_auto = 1'b0;
        l_cola_ack    = 1'b0;
        l_coin_ack    = 1'b0;
        l_coin_pulses = 0;
        forever begin
            @(negedge sys_clk);
            cola_hi   = (po_cola_drv && ack_en) ? cola_hi + 1 : 0;
            coin_hi   = (po_coin_drv && ack_en) ? coin_hi + 1 : 0;
            l_cola_hi = l_cola_drv ? l_cola_hi + 1 : 0;
            l_coin_hi = l_coin_drv ? l_coin_hi + 1 : 0;
            cola_ack_auto = (cola_hi == ACK_DELAY);
            coin_ack_auto = (coin_hi == ACK_DELAY);
            l_cola_ack    = (l_cola_hi == ACK_DELAY);
            l_coin_ack    = (l_coin_hi == ACK_DELAY);
            if (l_coin_drv && !l_prev) l_coin_pulses++;
            l_prev = l_coin_drv;
        end
    end

    // Monitor: compare every drive rise against the scoreboard.
    initial begin
        logic prev_cola;
        logic prev_coin;
        prev_cola = 1'b0;
        prev_coin = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (po_cola_drv === 1'b1 && !prev_cola) sb_pop(EV_COLA);
            if (po_coin_drv === 1'b1 && !prev_coin) sb_pop(EV_COIN);
            if (po_cola_drv || po_coin_drv) low_run = 0;
            else                            low_run++;
            prev_cola = po_cola_drv;
            prev_coin = po_coin_drv;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic cola, input logic [1:0] money);
        pi_cola  = cola;
        pi_money = money;
        @(negedge sys_clk);
        pi_cola  = 1'b0;
        pi_money = 2'd0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget && po_busy; i++) @(negedge sys_clk);
        check(name, po_busy, 1'b0);
    endtask

    task automatic wait_drv(input string name, input logic coin, input int budget);
        for (int i = 0; i < budget && !(coin ? po_coin_drv : po_cola_drv); i++) @(negedge sys_clk);
        check(name, coin ? po_coin_drv : po_cola_drv, 1'b1);
    endtask

    typedef struct {
        logic       cola;
        logic [1:0] money;
    } req_t;

    initial begin
        req_t burst[3];
        int   hi;
        burst[0] = '{1'b0, 2'd1};
        burst[1] = '{1'b0, 2'd2};
        burst[2] = '{1'b1, 2'd0};

        sys_rst    = 1'b1;
        pi_cola    = 1'b0;
        pi_money   = 2'd0;
        cola_stray = 1'b0;
        coin_stray = 1'b0;
        ack_en     = 1'b1;
        l_cola     = 1'b0;
        l_money    = 2'd0;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;

        // Reset state
        check("rst_cola_drv", po_cola_drv, 1'b0);
        check("rst_coin_drv", po_coin_drv, 1'b0);
        check("rst_busy",     po_busy,     1'b0);
        check("rst_coin_cnt", po_coin_cnt, 8'd20);
        check("rst_short",    po_short,    1'b0);
        check("rst_overflow", po_overflow, 1'b0);
        check("rst_fault",    po_fault,    1'b0);

        // Cola plus two coins, acks after 3 cycles
        expect_pulse(EV_COLA, 0);
        expect_pulse(EV_COIN, 1);
        expect_pulse(EV_COIN, 1);
        send(1'b1, 2'd2);
        check("t1_busy_on_accept",  po_busy,     1'b1);
        check("t1_drv_low_accept",  po_cola_drv, 1'b0);
        @(negedge sys_clk);
        check("t1_drv_high_next",   po_cola_drv, 1'b1);
        wait_idle("t1_idle", 60);
        check("t1_coin_cnt", po_coin_cnt, 8'd18);
        check("t1_short",    po_short,    1'b0);

        // Stray acks while idle
        cola_stray = 1'b1;
        coin_stray = 1'b1;
        @(negedge sys_clk);
        cola_stray = 1'b0;
        coin_stray = 1'b0;
        @(negedge sys_clk);
        check("stray_coin_cnt", po_coin_cnt, 8'd18);
        check("stray_busy",     po_busy,     1'b0);
        check("stray_coin_drv", po_coin_drv, 1'b0);

        // Three back-to-back requests: second queued, third dropped
        expect_pulse(EV_COIN, 0);
        expect_pulse(EV_COIN, 1);
        expect_pulse(EV_COIN, 1);
        for (int i = 0; i < 3; i++) begin
            pi_cola  = burst[i].cola;
            pi_money = burst[i].money;
            @(negedge sys_clk);
        end
        pi_cola  = 1'b0;
        pi_money = 2'd0;
        wait_idle("t3_idle", 80);
        check("t3_coin_cnt", po_coin_cnt, 8'd15);
        check("t3_overflow", po_overflow, 1'b1);
        check("t3_short",    po_short,    1'b0);

        // One-coin stock, two coins requested
        l_money = 2'd2;
        @(negedge sys_clk);
        l_money = 2'd0;
        for (int i = 0; i < 60 && l_busy; i++) @(negedge sys_clk);
        check("low_idle",     l_busy,        1'b0);
        check("low_coin_cnt", l_coin_cnt,    8'd0);
        check("low_short",    l_short,       1'b1);
        check("low_pulses",   l_coin_pulses, 1);
        check("low_overflow", l_overflow,    1'b0);

        // Reset while a coin drive is high
        expect_pulse(EV_COIN, 0);
        send(1'b0, 2'd3);
        wait_drv("t5_drv_up", 1'b1, 10);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("t5_cola_drv", po_cola_drv, 1'b0);
        check("t5_coin_drv", po_coin_drv, 1'b0);
        check("t5_busy",     po_busy,     1'b0);
        check("t5_coin_cnt", po_coin_cnt, 8'd20);
        check("t5_short",    po_short,    1'b0);
        check("t5_overflow", po_overflow, 1'b0);
        check("t5_fault",    po_fault,    1'b0);
        sys_rst = 1'b0;
        repeat (10) @(negedge sys_clk);
        check("t5_quiet_cnt",  po_coin_cnt, 8'd20);
        check("t5_quiet_busy", po_busy,     1'b0);

        // Cola ack withheld: timeout after 16 cycles
        ack_en = 1'b0;
        expect_pulse(EV_COLA, 0);
        send(1'b1, 2'd1);
        wait_drv("t6_drv_up", 1'b0, 5);
        hi = 0;
        while (po_cola_drv && hi < 40) begin
            hi++;
            @(negedge sys_clk);
        end
        check("t6_drv_width", hi,          16);
        check("t6_fault",     po_fault,    1'b1);
        check("t6_busy",      po_busy,     1'b1);
        check("t6_coin_drv",  po_coin_drv, 1'b0);
        ack_en = 1'b1;
        send(1'b1, 2'd2);
        send(1'b0, 2'd1);
        repeat (8) @(negedge sys_clk);
        check("t6_fault_held", po_fault,    1'b1);
        check("t6_ignored_ov", po_overflow, 1'b0);
        check("t6_ignored_ct", po_coin_cnt, 8'd20);
        check("t6_ignored_dr", po_cola_drv, 1'b0);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        check("t6_fault_clr", po_fault, 1'b0);
        check("t6_busy_clr",  po_busy,  1'b0);

        // Normal operation resumes after reset
        expect_pulse(EV_COIN, 0);
        send(1'b0, 2'd1);
        wait_idle("t7_idle", 40);
        check("t7_coin_cnt", po_coin_cnt, 8'd19);

        repeat (3) @(negedge sys_clk);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/refund_dispenser.md
REFUND_DISPENSER -- requirements
Module: refund_dispenser

Interface
REQ-001 SHALL have parameter COIN_INIT, default 8'd20: half-yuan coin stock loaded at reset.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 16: maximum number of cycles a drive may stay high without an ack.
REQ-003 SHALL have port sys_clk  input  1  single clock; all logic on the rising edge.
REQ-004 SHALL have port sys_rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pi_cola  input  1  one-cycle pulse from the vending FSM: release one cola.
REQ-006 SHALL have port pi_money  input  2  half-yuan coins to refund (0..3); sampled together with pi_cola.
REQ-007 SHALL have port cola_ack  input  1  cola mechanism done; only meaningful while po_cola_drv=1.
REQ-008 SHALL have port coin_ack  input  1  coin hopper ejected one coin; only meaningful while po_coin_drv=1.
REQ-009 SHALL have port po_cola_drv  output  1  cola release drive, held until ack.
REQ-010 SHALL have port po_coin_drv  output  1  single-coin eject drive, held until ack.
REQ-011 SHALL have port po_busy  output  1  high when state is not IDLE or the pending slot is valid.
REQ-012 SHALL have port po_coin_cnt  output  8  remaining coin stock.
REQ-013 SHALL have port po_short  output  1  sticky: at least one refund coin could not be paid.
REQ-014 SHALL have port po_overflow  output  1  sticky: a request was dropped.
REQ-015 SHALL have port po_fault  output  1  sticky: ack timeout occurred.

Function
REQ-016 SHALL treat a cycle with pi_cola=1 or pi_money!=0 as a request {cola, money}.
REQ-017 SHALL, when IDLE with no pending request, accept a request directly.
REQ-018 SHALL, when busy, store the request in a one-deep pending slot if that slot is empty.
REQ-019 SHALL, when busy with the pending slot full, drop the request and set po_overflow.
REQ-020 SHALL use FSM states IDLE, COLA, COIN, GAP, FAULT.
REQ-021 SHALL, for an accepted request with cola=1, go IDLE->COLA; otherwise go IDLE->COIN with the remaining count = money.
REQ-022 SHALL keep po_cola_drv=1 exactly while in COLA and po_coin_drv=1 exactly while in COIN; both drives are registered.
REQ-023 SHALL register the drive on the cycle after acceptance: a request accepted at edge N raises the drive at N+1.
REQ-024 SHALL, on an ack seen while its drive is high, drop the drive on the next edge.
REQ-025 SHALL, on cola_ack, go COLA->GAP if money!=0, else end the transaction.
REQ-026 SHALL, on coin_ack, decrement po_coin_cnt and the remaining count, then go COIN->GAP if remaining!=0, else end the transaction.
REQ-027 SHALL hold GAP for exactly one cycle, then go to COIN.
REQ-028 SHALL, when entering COIN with po_coin_cnt=0, not assert po_coin_drv, discard the remaining coins, set po_short, and end the transaction.
REQ-029 SHALL, at transaction end, go to IDLE if the pending slot is empty; otherwise load the pending request, clear the slot, and start it with the same one-cycle latency as from IDLE.
REQ-030 SHALL ignore acks that arrive while the matching drive is low.
REQ-031 SHALL, when a drive has been high for ACK_TIMEOUT consecutive cycles without an ack, go to FAULT, drop both drives, and set po_fault.
REQ-032 SHALL treat FAULT as absorbing: inputs ignored, pending slot cleared; exit only through reset.
REQ-033 SHALL never let po_coin_cnt wrap below 0.

Reset
REQ-034 SHALL, with sys_rst=1 at a rising edge, set: state IDLE, pending slot empty, po_cola_drv=0, po_coin_drv=0, po_busy=0, po_short=0, po_overflow=0, po_fault=0, po_coin_cnt=COIN_INIT, timeout counter 0.
REQ-035 SHALL let reset asserted mid-transaction abort that transaction with no further drive pulses and no stock change on that edge.

Verification
REQ-036 SHALL be checked with: pi_cola=1, pi_money=2, acks returned 3 cycles after each drive rises -> one cola drive, then two coin drives separated by one low cycle; po_coin_cnt 20->18; po_busy low after the last ack.
REQ-037 SHALL be checked with: three back-to-back requests while busy -> the 2nd is queued and executed after the 1st; the 3rd is dropped; po_overflow=1.
REQ-038 SHALL be checked with: COIN_INIT=1 and pi_money=2 -> one coin paid, po_coin_cnt=0, po_short=1, only one coin drive pulse.
REQ-039 SHALL be checked with: cola_ack withheld -> po_cola_drv falls after 16 cycles, po_fault=1, later requests ignored until sys_rst.
REQ-040 SHALL be checked with: a stray coin_ack in IDLE -> no change to stock or state.
REQ-041 SHALL be checked with: sys_rst asserted while po_coin_drv=1 -> all outputs at their reset values on the next cycle; po_coin_cnt=COIN_INIT.
